// File: rtl/fp32_pkg.sv
// rtl/fp32_pkg.sv - shared binary32 field widths, constants, state and class encodings
package fp32_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef logic [2:0] state_t;

    localparam state_t IDLE   = 3'd0;
    localparam state_t UNPACK = 3'd1;
    localparam state_t MULT   = 3'd2;
    localparam state_t NORM   = 3'd3;
    localparam state_t ROUND  = 3'd4;
    localparam state_t PACK   = 3'd5;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        NORMAL = 2'd1,
        INF    = 2'd2,
        NAN    = 2'd3
    } fp_class_t;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - split a binary32 word into sign, exponent, significand and class
module fp32_unpack
    import fp32_pkg::*;
(
    input  logic [31:0]       word,
    output logic              sign,
    output logic [EXP_W-1:0]  exponent,
    output logic [FRAC_W:0]   sig,
    output logic [1:0]        cls
);

    logic [FRAC_W-1:0] frac;

    assign sign     = word[31];
    assign exponent = word[30:23];
    assign frac     = word[22:0];

    // Denormals flush to zero, so a zero exponent never gets the hidden 1.
    assign sig = (exponent == '0) ? '0 : {1'b1, frac};

    always_comb begin
        cls = NORMAL;
        if (exponent == '0)
            cls = ZERO;
        else if (exponent == EXP_W'(EXP_MAX))
            cls = (frac == '0) ? INF : NAN;
    end

endmodule

// File: rtl/double_multiplier.sv
// rtl/double_multiplier.sv - multi-cycle binary32 multiplier, fixed 5-edge latency from start to done
module double_multiplier
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ready,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    output logic [31:0] res,
    output logic        done
);

    state_t state;

    logic [31:0] a_q, b_q;

    logic              ua_sign, ub_sign;
    logic [EXP_W-1:0]  ua_exp, ub_exp;
    logic [FRAC_W:0]   ua_sig, ub_sig;
    logic [1:0]        ua_cls, ub_cls;

    logic              sa_q, sb_q;
    logic [EXP_W-1:0]  ea_q, eb_q;
    logic [FRAC_W:0]   ma_q, mb_q;
    logic [1:0]        ca_q, cb_q;

    logic              sign_q;
    logic signed [9:0] exp_q;
    logic [47:0]       prod_q;
    logic [FRAC_W:0]   mant_q;
    logic              guard_q, round_q, sticky_q;
    logic [FRAC_W-1:0] frac_q;

    logic signed [9:0] mult_exp;
    logic              round_up;
    logic [FRAC_W+1:0] rounded;
    logic [31:0]       pack_res;

    fp32_unpack u_unpack_a (
        .word     (a_q),
        .sign     (ua_sign),
        .exponent (ua_exp),
        .sig      (ua_sig),
        .cls      (ua_cls)
    );

    fp32_unpack u_unpack_b (
        .word     (b_q),
        .sign     (ub_sign),
        .exponent (ub_exp),
        .sig      (ub_sig),
        .cls      (ub_cls)
    );

    assign mult_exp = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - $signed(10'(EXP_BIAS));

    // Nearest-even: bump on guard unless it is an exact tie with an even lsb.
    assign round_up = guard_q & (round_q | sticky_q | mant_q[0]);
    assign rounded  = {1'b0, mant_q} + {{(FRAC_W + 1){1'b0}}, round_up};

    always_comb begin
        pack_res = {sign_q, exp_q[7:0], frac_q};
        if (ca_q == NAN || cb_q == NAN)
            pack_res = QNAN;
        else if ((ca_q == INF && cb_q == ZERO) || (ca_q == ZERO && cb_q == INF))
            pack_res = QNAN;
        else if (ca_q == INF || cb_q == INF)
            pack_res = {sign_q, 8'hFF, 23'h0};
        else if (ca_q == ZERO || cb_q == ZERO)
            pack_res = {sign_q, 31'h0};
        else if (exp_q >= $signed(10'(EXP_MAX)))
            pack_res = {sign_q, 8'hFF, 23'h0};
        else if (exp_q <= 10'sd0)
            pack_res = {sign_q, 31'h0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            res      <= '0;
            done     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            ca_q     <= ZERO;
            cb_q     <= ZERO;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            prod_q   <= '0;
            mant_q   <= '0;
            guard_q  <= 1'b0;
            round_q  <= 1'b0;
            sticky_q <= 1'b0;
            frac_q   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // The done cycle still belongs to the finishing transaction.
                    if (ready && !done) begin
                        a_q   <= op1;
                        b_q   <= op2;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sa_q  <= ua_sign;
                    sb_q  <= ub_sign;
                    ea_q  <= ua_exp;
                    eb_q  <= ub_exp;
                    ma_q  <= ua_sig;
                    mb_q  <= ub_sig;
                    ca_q  <= ua_cls;
                    cb_q  <= ub_cls;
                    state <= MULT;
                end
                MULT: begin
                    sign_q <= sa_q ^ sb_q;
                    exp_q  <= mult_exp;
                    prod_q <= ma_q * mb_q;
                    state  <= NORM;
                end
                NORM: begin
                    if (prod_q[47]) begin
                        mant_q   <= prod_q[47:24];
                        guard_q  <= prod_q[23];
                        round_q  <= prod_q[22];
                        sticky_q <= |prod_q[21:0];
                        exp_q    <= exp_q + 10'sd1;
                    end else begin
                        mant_q   <= prod_q[46:23];
                        guard_q  <= prod_q[22];
                        round_q  <= prod_q[21];
                        sticky_q <= |prod_q[20:0];
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    if (rounded[FRAC_W+1]) begin
                        frac_q <= rounded[FRAC_W:1];
                        exp_q  <= exp_q + 10'sd1;
                    end else begin
                        frac_q <= rounded[FRAC_W-1:0];
                    end
                    state <= PACK;
                end
                PACK: begin
                    res   <= pack_res;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_double_multiplier.sv
// tb/tb_double_multiplier.sv - self-checking bench for double_multiplier
module tb_double_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready;
    logic [31:0] op1, op2;
    logic [31:0] res;
    logic        done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expect_res;
    } vec_t;

    vec_t vecs[$];

    double_multiplier dut (
        .clk   (clk),
        .rst   (rst),
        .ready (ready),
        .op1   (op1),
        .op2   (op2),
        .res   (res),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    // Reference: exact significand product rounded to 24 bits via remainder against half-ulp.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        int              ea, eb, e, shift;
        logic [22:0]     fa, fb;
        bit              s, za, zb, ia, ib, na, nb;
        longint unsigned ma, mb, p, keep, rem, half;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = a[22:0];
        fb = b[22:0];
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (fa == 0);
        ib = (eb == 255) && (fb == 0);
        na = (ea == 255) && (fa != 0);
        nb = (eb == 255) && (fb != 0);
        if (na || nb) return 32'h7FC00000;
        if ((ia && zb) || (za && ib)) return 32'h7FC00000;
        if (ia || ib) return {s, 8'hFF, 23'h0};
        if (za || zb) return {s, 31'h0};
        ma = (64'd1 << 23) | 64'(fa);
        mb = (64'd1 << 23) | 64'(fb);
        p  = ma * mb;
        shift = (p >= (64'd1 << 47)) ? 24 : 23;
        e = ea + eb - 127 + (shift - 23);
        keep = p >> shift;
        rem  = p - (keep << shift);
        half = 64'd1 << (shift - 1);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0};
        if (e <= 0) return {s, 31'h0};
        return {s, 8'(e), 23'(keep)};
    endfunction

    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op1 = a;
        op2 = b;
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic txn(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_v);
        int lat;
        start(a, b);
        wait_done(lat);
        check({name, " latency"}, 32'(lat), 32'd5);
        check(name, res, exp_v);
        @(posedge clk);
        #1;
        check({name, " done pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          c0;
        logic [31:0] ra, rb;

        vecs.push_back('{"neg inf x num", 32'hFF800000, 32'h45185B75, 32'hFF800000});
        vecs.push_back('{"inf x zero",    32'h7F800000, 32'h00000000, 32'h7FC00000});
        vecs.push_back('{"nan x one",     32'h7FC00001, 32'h3F800000, 32'h7FC00000});
        vecs.push_back('{"rounding",      32'h3F800001, 32'h3F800001, 32'h3F800002});
        vecs.push_back('{"norm shift",    32'h3FC00000, 32'h3FC00000, 32'h40100000});
        vecs.push_back('{"overflow",      32'h7F000000, 32'h40000000, 32'h7F800000});
        vecs.push_back('{"underflow",     32'h00800000, 32'h3F000000, 32'h00000000});
        vecs.push_back('{"two x 2.5",     32'h40000000, 32'h40200000, 32'h40A00000});
        vecs.push_back('{"denorm flush",  32'h00400000, 32'hC0000000, 32'h80000000});

        rst   = 1'b1;
        ready = 1'b0;
        op1   = '0;
        op2   = '0;
        repeat (3) @(negedge clk);
        check("reset res", res, 32'h0);
        check("reset done", {31'b0, done}, 32'd0);
        rst = 1'b0;

        // Operand change after the start edge must not affect the result.
        c0 = done_cnt;
        start(32'h40000000, 32'h40200000);
        op1 = 32'h3FA00000;
        op2 = 32'h3F800000;
        wait_done(lat);
        check("ignore ops latency", 32'(lat), 32'd5);
        check("ignore ops res", res, 32'h40A00000);
        repeat (10) @(negedge clk);
        check("ignore ops done count", 32'(done_cnt - c0), 32'd1);

        txn("neg zero", 32'h42C86666, 32'h80000000, 32'h80000000);
        @(negedge clk);
        op1 = 32'hFF800000;
        op2 = 32'h45185B75;
        c0 = done_cnt;
        repeat (10) @(negedge clk);
        check("no start done count", 32'(done_cnt - c0), 32'd0);
        check("no start res hold", res, 32'h80000000);

        foreach (vecs[i]) txn(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].expect_res);

        // Ready raised only during the done cycle is ignored.
        start(32'h3FC00000, 32'h3FC00000);
        wait_done(lat);
        check("done cycle latency", 32'(lat), 32'd5);
        op1 = 32'h40000000;
        op2 = 32'h40000000;
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
        c0 = done_cnt;
        repeat (10) @(negedge clk);
        check("done cycle ready count", 32'(done_cnt - c0), 32'd0);
        check("done cycle res hold", res, 32'h40100000);

        // Reset while the FSM is in MULT aborts the transaction.
        start(32'h40000000, 32'h40200000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        c0 = done_cnt;
        #1;
        check("abort res", res, 32'h0);
        check("abort done", {31'b0, done}, 32'd0);
        repeat (8) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort done count", 32'(done_cnt - c0), 32'd0);
        check("abort res after", res, 32'h0);
        txn("after reset", 32'h3FC00000, 32'h3FC00000, 32'h40100000);

        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 1) begin
                ra[30:23] = 8'($urandom_range(100, 154));
                rb[30:23] = 8'($urandom_range(100, 154));
            end
            txn($sformatf("rand%0d %h x %h", i, ra, rb), ra, rb, model(ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
